mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: READ_LAT, default 2, cycles MemRead and addr are held before read data is valid on dout; legal range 1..15.
REQ-002 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-003 clk  in  1  single clock, rising edge.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 req0 / req1  in  1  access request, port 0 = CPU data port, port 1 = loader/IO port.
REQ-006 we0 / we1  in  1  1 = write, 0 = read; valid while reqN high.
REQ-007 addr0 / addr1  in  32  byte address; valid while reqN high.
REQ-008 wdata0 / wdata1  in  32  write data; valid while reqN high.
REQ-009 rdata0 / rdata1  out  32  read data for port N.
REQ-010 ack0 / ack1  out  1  one-cycle completion pulse for port N.
REQ-011 MemRead  out  1  read strobe to data memory.
REQ-012 MemWrite  out  1  write strobe to data memory.
REQ-013 addr  out  32  memory address; memory decodes addr[13:0].
REQ-014 din  out  32  memory write data.
REQ-015 dout  in  32  memory read data, valid READ_LAT cycles after a held MemRead.
REQ-016 busy  out  1  high whenever state is not IDLE.

Function
REQ-017 FSM states: IDLE, WR, RD, RSP; Moore outputs only.
REQ-018 IDLE: if any req is high, latch owner, we, addr and wdata of the granted port at the clock edge, then go to WR (we=1) or RD (we=0); otherwise stay in IDLE.
REQ-019 Arbitration in IDLE:
- One request high: grant that port.
- Both high: grant the port not equal to last_grant (round-robin); last_grant updates on every grant.
REQ-020 WR lasts exactly 1 cycle:
- MemWrite=1, addr/din from latched values, ack[owner]=1.
- Next state IDLE.
REQ-021 RD:
- MemRead=1 and addr held from the latched value.
- A latency counter counts 0..READ_LAT-1; at count READ_LAT-1 the FSM goes to RSP.
REQ-022 RSP lasts 1 cycle:
- MemRead=0, ack[owner]=1.
- rdata[owner] = dout combinationally; the rdata register for that port loads dout at the end of the cycle.
- Next state IDLE.
REQ-023 Outside RSP, rdataN shows its held register; the non-owner's rdata is never changed.
REQ-024 Latency, request sampled in IDLE at cycle t:
- Write: MemWrite and ack at t+1.
- Read: MemRead at t+1..t+READ_LAT, ack at t+READ_LAT+1.
REQ-025 Request rules:
- A requester drops req in the cycle after its ack unless it is issuing a new transaction.
- A new request is granted in that same IDLE cycle, giving back-to-back throughput.
REQ-026 Request changes outside IDLE are ignored; latched values alone drive memory.
REQ-027 MemRead and MemWrite are never high simultaneously, and never high in IDLE.
REQ-028 addr and din hold their last latched values in IDLE (no glitching to 0).

Reset
REQ-029 rst_n low immediately forces:
- state IDLE, counter 0, last_grant=1 (port 0 wins the first tie).
- MemRead=0, MemWrite=0, ack0=ack1=0, busy=0.
- addr=0, din=0, rdata0=rdata1=0.
REQ-030 Reset mid-transaction aborts it: no ack is issued, and a partly completed read leaves rdata at 0.
REQ-031 After rst_n rises, the first request is sampled on the first rising clk edge.

Structure
REQ-032 A shared include/package holds the state encodings, the READ_LAT default and the port-index constants.
REQ-033 The 2-way round-robin grant logic (reqs, last_grant -> grant) is a sub-module, rr_arbiter_2.

Verification
REQ-034 Single write: req0=1, we0=1, addr0=0x10, wdata0=0xDEADBEEF at t -> MemWrite=1, addr=0x10, din=0xDEADBEEF, ack0=1 at t+1; busy=0 at t+2.
REQ-035 Single read, READ_LAT=2, memory model returning 0x12345678 -> MemRead high at t+1 and t+2; ack1=1 and rdata1=0x12345678 at t+3; rdata1 holds that value afterwards.
REQ-036 Tie after reset: req0 and req1 both held for reads -> grant order 0,1,0,1; acks spaced READ_LAT+2 cycles apart; rdata0 never disturbed by port-1 reads.
REQ-037 Back-to-back writes from port 0 only -> ack0 every 2 cycles, and MemWrite never overlaps MemRead.
REQ-038 rst_n low during an RD cycle -> MemRead=0 and busy=0 immediately, no ack, rdataN=0; the next request completes normally.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-port data-memory arbiter: state encoding,
// default read latency and port indices.
package mem_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WR   = 2'd1,
      RD   = 2'd2,
      RSP  = 2'd3
   } state_t;

   localparam int   READ_LAT_DEF = 2;
   localparam int   CNT_W        = 4;
   localparam logic PORT0        = 1'b0;
   localparam logic PORT1        = 1'b1;

endpackage

// File: rtl/mem_arbiter_rr.sv
// Two-way round-robin grant: a lone requester wins, a tie goes to the port
// that did not win last time.
module rr_arbiter_2
   import mem_arbiter_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last_grant,
   output logic       gnt_vld,
   output logic       grant
);

   always_comb begin
      gnt_vld = |req;
      grant   = PORT0;
      if (&req)
         grant = ~last_grant;
      else if (req[1])
         grant = PORT1;
   end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a CPU data port and a loader/IO port onto one synchronous data
// memory; Moore FSM IDLE -> WR | RD..RSP -> IDLE.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int READ_LAT = READ_LAT_DEF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req0,
   input  logic        req1,
   input  logic        we0,
   input  logic        we1,
   input  logic [31:0] addr0,
   input  logic [31:0] addr1,
   input  logic [31:0] wdata0,
   input  logic [31:0] wdata1,
   output logic [31:0] rdata0,
   output logic [31:0] rdata1,
   output logic        ack0,
   output logic        ack1,
   output logic        MemRead,
   output logic        MemWrite,
   output logic [31:0] addr,
   output logic [31:0] din,
   input  logic [31:0] dout,
   output logic        busy
);

   state_t             state, state_nxt;
   logic               owner;
   logic               last_grant;
   logic [CNT_W-1:0]   cnt;
   logic [31:0]        addr_q, din_q;
   logic [31:0]        rdata0_q, rdata1_q;
   logic               gnt_vld, grant;
   logic               grant_we;

   rr_arbiter_2 u_rr (
      .req        ({req1, req0}),
      .last_grant (last_grant),
      .gnt_vld    (gnt_vld),
      .grant      (grant)
   );

   assign grant_we = (grant == PORT1) ? we1 : we0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         owner      <= PORT0;
         last_grant <= PORT1;
         cnt        <= '0;
         addr_q     <= '0;
         din_q      <= '0;
         rdata0_q   <= '0;
         rdata1_q   <= '0;
      end else begin
         state <= state_nxt;
         // Request inputs are only looked at here; later states run purely on the latched copy.
         if (state == IDLE && gnt_vld) begin
            owner      <= grant;
            last_grant <= grant;
            addr_q     <= (grant == PORT1) ? addr1  : addr0;
            din_q      <= (grant == PORT1) ? wdata1 : wdata0;
         end
         cnt <= (state == RD) ? cnt + 1'b1 : '0;
         if (state == RSP) begin
            if (owner == PORT1)
               rdata1_q <= dout;
            else
               rdata0_q <= dout;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      MemRead   = 1'b0;
      MemWrite  = 1'b0;
      ack0      = 1'b0;
      ack1      = 1'b0;
      busy      = (state != IDLE);
      rdata0    = rdata0_q;
      rdata1    = rdata1_q;
      unique case (state)
         IDLE: begin
            if (gnt_vld)
               state_nxt = grant_we ? WR : RD;
         end
         WR: begin
            MemWrite  = 1'b1;
            ack0      = (owner == PORT0);
            ack1      = (owner == PORT1);
            state_nxt = IDLE;
         end
         RD: begin
            MemRead = 1'b1;
            if (cnt == CNT_W'(READ_LAT - 1))
               state_nxt = RSP;
         end
         RSP: begin
            // Memory data is forwarded in the ack cycle so the requester need not wait for the register.
            ack0      = (owner == PORT0);
            ack1      = (owner == PORT1);
            if (owner == PORT1)
               rdata1 = dout;
            else
               rdata0 = dout;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign addr = addr_q;
   assign din  = din_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized scoreboard bench for mem_arbiter with an array memory model and
// per-port expected-response queues.
module tb_mem_arbiter;

   localparam int READ_LAT = 2;

   typedef struct {
      bit          we;
      logic [31:0] addr;
      logic [31:0] data;
      int          issue;
      int          lat;
   } txn_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
   logic [31:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
   logic [31:0] rdata0, rdata1, addr, din, dout;
   logic        ack0, ack1, MemRead, MemWrite, busy;

   mem_arbiter #(.READ_LAT(READ_LAT)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .rdata0(rdata0), .rdata1(rdata1), .ack0(ack0), .ack1(ack1),
      .MemRead(MemRead), .MemWrite(MemWrite), .addr(addr), .din(din),
      .dout(dout), .busy(busy)
   );

   always #5 clk = ~clk;

   int compared = 0, mismatched = 0;
   int cyc = 0;
   int ovl_err = 0, hold_err = 0;
   txn_t q0[$], q1[$];
   int ack_p[$], ack_c[$];
   logic [31:0] exp_rd [2];

   // Memory seen by the DUT: word array, returns data only after READ_LAT held read cycles.
   bit [31:0] mem [4096];
   bit        mem_v [4096];
   int        rd_run = 0;
   // Reference memory contents as the bench expects them.
   bit [31:0] ref_mem [4096];
   bit        ref_v [4096];

   function automatic logic [31:0] init_val(input int i);
      return 32'hC0DE_0000 | 32'(i);
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      if (MemWrite) begin
         mem[addr[13:2]]   <= din;
         mem_v[addr[13:2]] <= 1'b1;
      end
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) rd_run <= 0;
      else        rd_run <= MemRead ? rd_run + 1 : 0;
   end

   always_comb begin
      dout = 32'hBAD0_BAD0;
      if (busy && !MemRead && rd_run == READ_LAT)
         dout = mem_v[addr[13:2]] ? mem[addr[13:2]] : init_val(int'(addr[13:2]));
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Issue one transaction on port p (called just after a rising edge) and record its expected outcome.
   task automatic issue(input int p, input bit we, input logic [31:0] a, input logic [31:0] d,
                        input int lat);
      txn_t t;
      int   i;
      i       = int'(a[13:2]);
      t.we    = we;
      t.addr  = a;
      t.issue = cyc;
      t.lat   = lat;
      if (we) begin
         ref_mem[i] = d;
         ref_v[i]   = 1'b1;
         t.data     = d;
      end else begin
         t.data = ref_v[i] ? ref_mem[i] : init_val(i);
      end
      if (p == 0) begin
         q0.push_back(t);
         req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d;
      end else begin
         q1.push_back(t);
         req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d;
      end
   endtask

   task automatic drop(input int p);
      if (p == 0) req0 = 1'b0;
      else        req1 = 1'b0;
   endtask

   // Returns one time unit after the edge that ends the ack cycle.
   task automatic wait_ack(input int p);
      int n;
      bit got;
      n   = 0;
      got = 1'b0;
      while (!got && n < 200) begin
         @(negedge clk);
         n++;
         if ((p == 0) ? ack0 : ack1) got = 1'b1;
      end
      if (!got) begin
         compared++;
         mismatched++;
         $display("FAIL ack_timeout: port%0d got no ack in %0d cycles, ack required", p, n);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic rand_port(input int p, input int n);
      bit          we;
      logic [31:0] a;
      int          gap;
      for (int k = 0; k < n; k++) begin
         we  = 1'($urandom_range(0, 1));
         a   = {8'($urandom), 10'h0, 1'(p), 1'b0, 10'($urandom_range(0, 255)), 2'b00};
         gap = $urandom_range(0, 2);
         issue(p, we, a, $urandom, -1);
         wait_ack(p);
         if (gap > 0) begin
            drop(p);
            repeat (gap) begin
               @(posedge clk);
               #1;
            end
         end
      end
      drop(p);
   endtask

   task automatic tie_seq(input int p);
      issue(p, 1'b0, (p == 0) ? 32'h40 : 32'h1040, 32'h0, -1);
      wait_ack(p);
      issue(p, 1'b0, (p == 0) ? 32'h44 : 32'h1044, 32'h0, -1);
      wait_ack(p);
      drop(p);
   endtask

   // Monitor: pops the expected response whenever a port acks.
   initial begin
      txn_t        t;
      logic        a;
      logic [31:0] rd;
      exp_rd[0] = '0;
      exp_rd[1] = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            exp_rd[0] = '0;
            exp_rd[1] = '0;
         end else begin
            if ((MemRead && MemWrite) || (!busy && (MemRead || MemWrite))) ovl_err++;
            for (int p = 0; p < 2; p++) begin
               a  = (p == 0) ? ack0 : ack1;
               rd = (p == 0) ? rdata0 : rdata1;
               if (a) begin
                  ack_p.push_back(p);
                  ack_c.push_back(cyc);
                  if (((p == 0) ? q0.size() : q1.size()) == 0) begin
                     chk($sformatf("spurious_ack%0d", p), 32'(a), 32'(0));
                  end else begin
                     t = (p == 0) ? q0.pop_front() : q1.pop_front();
                     if (t.lat >= 0)
                        chk($sformatf("latency%0d", p), 32'(cyc - t.issue), 32'(t.lat));
                     if (t.we) begin
                        chk($sformatf("wr_strobe%0d", p), {MemRead, MemWrite}, 32'b01);
                        chk($sformatf("wr_addr%0d", p), addr, t.addr);
                        chk($sformatf("wr_din%0d", p), din, t.data);
                        if (rd !== exp_rd[p]) hold_err++;
                     end else begin
                        chk($sformatf("rd_data%0d", p), rd, t.data);
                        chk($sformatf("rd_cycles%0d", p), 32'(rd_run), 32'(READ_LAT));
                        exp_rd[p] = t.data;
                     end
                  end
               end else if (rd !== exp_rd[p]) begin
                  hold_err++;
               end
            end
         end
      end
   end

   initial begin
      int base;
      repeat (3) @(negedge clk);
      chk("rst_busy", 32'(busy), 32'(0));
      chk("rst_strobes", {MemRead, MemWrite, ack0, ack1}, 32'(0));
      chk("rst_addr", addr, 32'h0);
      chk("rst_din", din, 32'h0);
      chk("rst_rdata0", rdata0, 32'h0);
      chk("rst_rdata1", rdata1, 32'h0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Single write from port 0.
      issue(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 1);
      wait_ack(0);
      drop(0);
      @(negedge clk);
      chk("busy_after_write", 32'(busy), 32'(0));
      @(posedge clk);
      #1;

      // Port 1 stores a word, then reads it back.
      issue(1, 1'b1, 32'h1200, 32'h1234_5678, 1);
      wait_ack(1);
      issue(1, 1'b0, 32'h1200, 32'h0, READ_LAT + 1);
      wait_ack(1);
      drop(1);
      repeat (3) @(posedge clk);
      #1;
      chk("rdata1_held", rdata1, 32'h1234_5678);

      // Reset asserted in the middle of a read.
      req0 = 1'b1; we0 = 1'b0; addr0 = 32'h40;
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("abort_mem_read", 32'(MemRead), 32'(0));
      chk("abort_busy", 32'(busy), 32'(0));
      chk("abort_ack", {ack0, ack1}, 32'(0));
      chk("abort_rdata1", rdata1, 32'h0);
      req0 = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Both ports reading continuously right after reset: strict alternation.
      base = ack_p.size();
      fork
         tie_seq(0);
         tie_seq(1);
      join
      if (ack_p.size() >= base + 4) begin
         for (int i = 0; i < 4; i++)
            chk($sformatf("tie_order%0d", i), 32'(ack_p[base+i]), 32'(i % 2));
         for (int i = 1; i < 4; i++)
            chk($sformatf("tie_spacing%0d", i), 32'(ack_c[base+i] - ack_c[base+i-1]),
                32'(READ_LAT + 2));
      end else begin
         chk("tie_ack_count", 32'(ack_p.size() - base), 32'(4));
      end

      // Back-to-back writes from port 0.
      base = ack_p.size();
      for (int i = 0; i < 6; i++) begin
         issue(0, 1'b1, 32'h80 + 32'(4 * i), $urandom, 1);
         wait_ack(0);
      end
      drop(0);
      if (ack_p.size() >= base + 6) begin
         for (int i = 1; i < 6; i++)
            chk($sformatf("b2b_spacing%0d", i), 32'(ack_c[base+i] - ack_c[base+i-1]), 32'(2));
      end else begin
         chk("b2b_ack_count", 32'(ack_p.size() - base), 32'(6));
      end

      // Random traffic on both ports in disjoint address regions.
      fork
         rand_port(0, 40);
         rand_port(1, 40);
      join
      repeat (4) @(posedge clk);
      @(negedge clk);

      chk("rw_overlap", 32'(ovl_err), 32'(0));
      chk("rdata_hold", 32'(hold_err), 32'(0));
      chk("pending_txns", 32'(q0.size() + q1.size()), 32'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
